// File: rtl/clause_rx_queue.sv
// Per-engine receive queue: show-ahead FIFO between the clause arbiter and one BCP engine.
// Every output is decoded from registered state, so the arbiter can sample full_out in its grant cycle.
module clause_rx_queue #(
  parameter int LIT_IDX_MAX = 1024,
  parameter int VAR_W       = $clog2(LIT_IDX_MAX) + 1,
  parameter int CLA_LENGTH  = 3,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        grant_in,
  input  logic [CLA_LENGTH*VAR_W-1:0] clause_in,
  output logic                        full_out,
  output logic                        clause_valid_out,
  input  logic                        clause_ready_in,
  output logic [CLA_LENGTH*VAR_W-1:0] clause_out,
  output logic [CLA_LENGTH-1:0]       lit_valid_out,
  input  logic                        flush_in,
  output logic [CNT_W-1:0]            count_out,
  output logic                        overflow_err_out
);

  localparam int CLA_W = CLA_LENGTH * VAR_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [CLA_W-1:0] storage [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic             full, valid, push, pop;

  assign full  = (count_reg == FULL_CNT);
  assign valid = (count_reg != '0);
  // A pop never frees a slot for the same cycle's grant: push looks at registered full only.
  assign push  = grant_in & ~full & ~flush_in;
  assign pop   = valid & clause_ready_in & ~flush_in;

  always_comb begin
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg | (grant_in & full);
    if (flush_in) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage needs no reset: stale entries are masked by count_reg.
  always_ff @(posedge clock) begin
    if (push) begin
      storage[wr_ptr_reg] <= clause_in;
    end
  end

  assign full_out         = full;
  assign clause_valid_out = valid;
  assign count_out        = count_reg;
  assign overflow_err_out = overflow_reg;
  assign clause_out       = valid ? storage[rd_ptr_reg] : '0;

  for (genvar gi = 0; gi < CLA_LENGTH; gi++) begin : g_lit
    assign lit_valid_out[gi] = |clause_out[gi*VAR_W +: VAR_W];
  end

endmodule

// File: tb/tb_clause_rx_queue.sv
// Scoreboard bench for clause_rx_queue: stimulus enqueues accepted clauses, a pre-edge monitor
// compares the DUT head/status against the queue and retires entries on each handshake.
module tb_clause_rx_queue;

  localparam int VAR_W      = 11;
  localparam int CLA_LENGTH = 3;
  localparam int CLA_W      = CLA_LENGTH * VAR_W;
  localparam int DEPTH      = 4;
  localparam int CNT_W      = 3;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  grant_in = 1'b0;
  logic [CLA_W-1:0]      clause_in = '0;
  logic                  clause_ready_in = 1'b0;
  logic                  flush_in = 1'b0;
  logic                  full_out;
  logic                  clause_valid_out;
  logic [CLA_W-1:0]      clause_out;
  logic [CLA_LENGTH-1:0] lit_valid_out;
  logic [CNT_W-1:0]      count_out;
  logic                  overflow_err_out;

  clause_rx_queue dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .grant_in         (grant_in),
    .clause_in        (clause_in),
    .full_out         (full_out),
    .clause_valid_out (clause_valid_out),
    .clause_ready_in  (clause_ready_in),
    .clause_out       (clause_out),
    .lit_valid_out    (lit_valid_out),
    .flush_in         (flush_in),
    .count_out        (count_out),
    .overflow_err_out (overflow_err_out)
  );

  always #5 clock = ~clock;

  logic [CLA_W-1:0] exp_q[$];
  logic             err_m = 1'b0;
  int               checks = 0;
  int               failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [CLA_LENGTH-1:0] lits_nonzero(input logic [CLA_W-1:0] c);
    logic [CLA_LENGTH-1:0] r;
    for (int k = 0; k < CLA_LENGTH; k++) r[k] = (c[k*VAR_W +: VAR_W] != '0);
    return r;
  endfunction

  function automatic logic [CLA_W-1:0] rand_clause();
    logic [CLA_W-1:0] c;
    for (int k = 0; k < CLA_LENGTH; k++) begin
      if ($urandom_range(0, 3) == 0) c[k*VAR_W +: VAR_W] = '0;
      else c[k*VAR_W +: VAR_W] = VAR_W'($urandom_range(1, 2047));
    end
    return c;
  endfunction

  // Monitor: samples 2 ns before the rising edge, while this cycle's inputs are stable.
  always @(negedge clock) begin
    logic [CLA_W-1:0] head;
    #3;
    if (reset_n) begin
      head = (exp_q.size() != 0) ? exp_q[0] : '0;
      chk("count", 64'(count_out), 64'(exp_q.size()));
      chk("valid", 64'(clause_valid_out), 64'(exp_q.size() != 0));
      chk("full", 64'(full_out), 64'(exp_q.size() == DEPTH));
      chk("clause", 64'(clause_out), 64'(head));
      chk("lit_valid", 64'(lit_valid_out), 64'(lits_nonzero(head)));
      chk("overflow_err", 64'(overflow_err_out), 64'(err_m));
      if (exp_q.size() != 0 && clause_ready_in && !flush_in) begin
        head = exp_q.pop_front();
        $display("POP clause=%09h dut=%09h lit_valid=%03b", head, clause_out, lit_valid_out);
      end
    end
  end

  // One clock of stimulus; the model is updated just after the edge it applies to.
  task automatic cycle(input logic g, input logic [CLA_W-1:0] d, input logic r, input logic f);
    logic full_m, do_push, ovf;
    @(negedge clock);
    #1;
    grant_in = g; clause_in = d; clause_ready_in = r; flush_in = f;
    full_m  = (exp_q.size() == DEPTH);
    do_push = g && !full_m && !f;
    ovf     = g && full_m;
    @(posedge clock);
    #1;
    if (f) exp_q.delete();
    if (do_push) begin
      exp_q.push_back(d);
      $display("PUSH clause=%09h occupancy=%0d", d, exp_q.size());
    end
    if (ovf) err_m = 1'b1;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_count"}, 64'(count_out), 64'd0);
    chk({tag, "_valid"}, 64'(clause_valid_out), 64'd0);
    chk({tag, "_full"}, 64'(full_out), 64'd0);
    chk({tag, "_clause"}, 64'(clause_out), 64'd0);
    chk({tag, "_lit_valid"}, 64'(lit_valid_out), 64'd0);
    chk({tag, "_err"}, 64'(overflow_err_out), 64'd0);
  endtask

  task automatic mid_reset();
    @(negedge clock);
    #1;
    grant_in = 1'b0; clause_ready_in = 1'b0; flush_in = 1'b0;
    #1 reset_n = 1'b0;
    #1 check_zero_outputs("async_reset");
    exp_q.delete();
    err_m = 1'b0;
    @(negedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CLA_W-1:0] a;
    logic [CLA_W-1:0] junk;
    a = {11'h000, 11'h407, 11'h005};  // literals 5, -7, 0
    #3 check_zero_outputs("power_on_reset");
    @(negedge clock);
    #1 reset_n = 1'b1;

    // Fill to full with the engine stalled, then drain in order.
    cycle(1'b1, a, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_clause(), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Push into empty: valid only from the following cycle.
    cycle(1'b1, rand_clause(), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush with a concurrent grant: nothing stored, no error.
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_clause(), 1'b0, 1'b0);
    cycle(1'b1, rand_clause(), 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Steady push+pop at occupancy 2; pointers wrap several times.
    for (int i = 0; i < 2; i++) cycle(1'b1, rand_clause(), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, rand_clause(), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Grant while full with a same-cycle pop: dropped, sticky error survives flush.
    for (int i = 0; i < 4; i++) cycle(1'b1, rand_clause(), 1'b0, 1'b0);
    junk = rand_clause();
    cycle(1'b1, junk, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset with three entries held.
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_clause(), 1'b0, 1'b0);
    mid_reset();
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 9) < 6, rand_clause(), $urandom_range(0, 1) == 1,
            $urandom_range(0, 19) == 0);
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
    @(negedge clock);
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
